alu_result_reader: RTL

- Read-side companion to the ALU store block.
- Holds a small result RAM that the ALU store side fills one word at a time (wr_en/wr_addr/wr_data).
- On a read command, drains a contiguous, wrap-around range of stored results to a downstream consumer over a valid/ready stream.
- Marks the final beat and pulses completion when the range is done.

---
 rtl/alu_result_reader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_result_reader.sv
// Result RAM filled by the ALU store side and drained as a wrap-around address
// range over a valid/ready stream, one beat every two cycles at most.
module alu_result_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W:0]   rd_len,
    output logic              busy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_LEN = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, FIN} state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   eff_len;
    logic              hs;
    logic              last_beat;
    logic              rd_issue;
    logic              rd_hit;

    assign eff_len   = (rd_len > DEPTH_LEN) ? DEPTH_LEN : rd_len;
    assign addr_inc  = addr + 1'b1;
    assign hs        = (state == STREAM) && out_ready;
    assign last_beat = (cnt == ONE_LEN);

    // A read is issued when a non-empty command is accepted, or when a
    // non-final beat is handed off and the next word has to be fetched.
    assign rd_issue = ((state == IDLE) && rd_start && (eff_len != '0)) ||
                      (hs && !last_beat);
    assign rd_addr  = (state == IDLE) ? rd_base : addr_inc;
    assign rd_hit   = wr_en && (wr_addr == rd_addr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rd_start) begin
                    state_next = (eff_len == '0) ? FIN : FETCH;
                end
            end
            FETCH: state_next = STREAM;
            STREAM: begin
                if (out_ready) begin
                    state_next = last_beat ? FIN : FETCH;
                end
            end
            FIN: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        out_valid = (state == STREAM);
        out_last  = (state == STREAM) && last_beat;
        done      = (state == FIN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr     <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_start) begin
                        addr <= rd_base;
                        cnt  <= eff_len;
                    end
                end
                FETCH: out_data <= rd_q;
                STREAM: begin
                    if (out_ready) begin
                        addr <= addr_inc;
                        cnt  <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
    end

    // Write-first: a write landing on the word being read wins the beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (rd_issue) begin
            rd_q <= rd_hit ? wr_data : ram[rd_addr];
        end
    end

endmodule
